// File: rtl/stq_fwd_param_if.sv
// Dcache store-drain handshake between the store queue (master) and the Dcache (slave).
interface stq_fwd_param_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              Dcache_st_req;
  logic [ADDR_W-1:0] Dcache_st_addr;
  logic [DATA_W-1:0] Dcache_st_value;
  logic              Dcache_st_ack;

  modport master (
    output Dcache_st_req,
    output Dcache_st_addr,
    output Dcache_st_value,
    input  Dcache_st_ack
  );

  modport slave (
    input  Dcache_st_req,
    input  Dcache_st_addr,
    input  Dcache_st_value,
    output Dcache_st_ack
  );
endinterface

// File: rtl/stq_fwd_param.sv
// Parametrised store queue: in-order allocation, issue-time fill, store-to-load
// forwarding (youngest older match first), commit tracking, Dcache drain and flush.
module stq_fwd_param #(
  parameter int unsigned STQ_DEPTH = 16,
  parameter int unsigned STQ_BITS  = 4,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_wr_mem0,
  input  logic                id_wr_mem1,
  output logic [STQ_BITS:0]   stq_disp_age0,
  output logic [STQ_BITS:0]   stq_disp_age1,
  output logic [STQ_BITS:0]   stq_free,
  output logic                stq_overflow,
  input  logic                rs_st_valid0,
  input  logic [STQ_BITS:0]   rs_st_age0,
  input  logic [ADDR_W-1:0]   rs_st_addr0,
  input  logic [DATA_W-1:0]   rs_st_value0,
  input  logic                rs_st_valid1,
  input  logic [STQ_BITS:0]   rs_st_age1,
  input  logic [ADDR_W-1:0]   rs_st_addr1,
  input  logic [DATA_W-1:0]   rs_st_value1,
  input  logic                ld_valid,
  input  logic [STQ_BITS:0]   ld_age,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_fwd_hit,
  output logic                ld_fwd_wait,
  output logic [DATA_W-1:0]   ld_fwd_value,
  input  logic [1:0]          rob_retire_st,
  input  logic                flush,
  stq_fwd_param_if.master     dc
);

  typedef logic [STQ_BITS:0]   tag_t;
  typedef logic [STQ_BITS-1:0] idx_t;

  tag_t              r_head;
  tag_t              r_cmt;
  tag_t              r_tail;
  logic [ADDR_W-1:0] r_addr  [STQ_DEPTH];
  logic [DATA_W-1:0] r_value [STQ_DEPTH];
  logic [STQ_DEPTH-1:0] r_ready;

  tag_t        w_occ;
  tag_t        w_free;
  logic [1:0]  w_disp_cnt;
  logic        w_overflow;
  logic        w_alloc;
  tag_t        w_age0;
  tag_t        w_age1;
  tag_t        w_cmt_next;
  logic        w_drain;
  tag_t        w_fill_span;
  tag_t        w_fill_off0;
  tag_t        w_fill_off1;
  logic        w_fill0;
  logic        w_fill1;
  tag_t        w_ld_span;
  idx_t        w_idx;
  logic        w_hit;
  logic        w_wait;
  logic [DATA_W-1:0] w_fwd_value;

  assign w_occ      = r_tail - r_head;
  assign w_free     = tag_t'(STQ_DEPTH) - w_occ;
  assign w_disp_cnt = {1'b0, id_wr_mem0} + {1'b0, id_wr_mem1};
  assign w_overflow = tag_t'(w_disp_cnt) > w_free;
  assign w_alloc    = !w_overflow && !flush;
  assign w_age0     = r_tail;
  assign w_age1     = r_tail + tag_t'(id_wr_mem0);
  assign w_cmt_next = r_cmt + tag_t'(rob_retire_st);
  assign w_drain    = dc.Dcache_st_req && dc.Dcache_st_ack;

  // Fill window [cmt, tail) tested as an offset from cmt so wrapped tags order correctly.
  assign w_fill_span = r_tail - r_cmt;
  assign w_fill_off0 = rs_st_age0 - r_cmt;
  assign w_fill_off1 = rs_st_age1 - r_cmt;
  assign w_fill0     = rs_st_valid0 && !flush && (w_fill_off0 < w_fill_span);
  assign w_fill1     = rs_st_valid1 && !flush && (w_fill_off1 < w_fill_span);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_ready <= '0;
      for (int unsigned i = 0; i < STQ_DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_value[i] <= '0;
      end
    end else begin
      r_head <= r_head + tag_t'(w_drain);
      r_cmt  <= w_cmt_next;
      if (flush)
        r_tail <= w_cmt_next;
      else if (w_alloc)
        r_tail <= r_tail + tag_t'(w_disp_cnt);

      if (w_alloc && id_wr_mem0) r_ready[w_age0[STQ_BITS-1:0]] <= 1'b0;
      if (w_alloc && id_wr_mem1) r_ready[w_age1[STQ_BITS-1:0]] <= 1'b0;
      if (w_fill0) begin
        r_addr[rs_st_age0[STQ_BITS-1:0]]  <= rs_st_addr0;
        r_value[rs_st_age0[STQ_BITS-1:0]] <= rs_st_value0;
        r_ready[rs_st_age0[STQ_BITS-1:0]] <= 1'b1;
      end
      if (w_fill1) begin
        r_addr[rs_st_age1[STQ_BITS-1:0]]  <= rs_st_addr1;
        r_value[rs_st_age1[STQ_BITS-1:0]] <= rs_st_value1;
        r_ready[rs_st_age1[STQ_BITS-1:0]] <= 1'b1;
      end
      if (w_drain) r_ready[r_head[STQ_BITS-1:0]] <= 1'b0;
    end
  end

  // Scanning oldest to youngest and letting each deciding entry overwrite the
  // result leaves the youngest deciding entry in charge.
  assign w_ld_span = ld_age - r_head;

  always_comb begin
    w_hit       = 1'b0;
    w_wait      = 1'b0;
    w_fwd_value = '0;
    w_idx       = '0;
    if (ld_valid) begin
      for (int unsigned i = 0; i < STQ_DEPTH; i++) begin
        if (tag_t'(i) < w_ld_span) begin
          w_idx = r_head[STQ_BITS-1:0] + idx_t'(i);
          if (!r_ready[w_idx]) begin
            w_wait      = 1'b1;
            w_hit       = 1'b0;
            w_fwd_value = '0;
          end else if (((r_addr[w_idx] ^ ld_addr) >> 3) == '0) begin
            w_wait      = 1'b0;
            w_hit       = 1'b1;
            w_fwd_value = r_value[w_idx];
          end
        end
      end
    end
  end

  assign ld_fwd_hit   = w_hit;
  assign ld_fwd_wait  = w_wait;
  assign ld_fwd_value = w_fwd_value;

  assign stq_disp_age0 = w_age0;
  assign stq_disp_age1 = w_age1;
  assign stq_free      = w_free;
  assign stq_overflow  = w_overflow;

  assign dc.Dcache_st_req   = (r_head != r_cmt);
  assign dc.Dcache_st_addr  = r_addr[r_head[STQ_BITS-1:0]];
  assign dc.Dcache_st_value = r_value[r_head[STQ_BITS-1:0]];

endmodule
